fmap_loader_14x14: RTL and testbench
====================================

# fmap_loader_14x14

Stream-to-frame writer for the pooling stage. It accepts 8-bit convolution output pixels one per handshake in row-major order and packs them into the flat 14x14 feature-map bus the 2x2/7x7 max-pool selector reads. Once a frame is complete, it sweeps the pool index 0..48, one per cycle, then holds the frame until the consumer acknowledges it. It sits between the conv engine output and the pooling stage.

## Interface
- IntSize, 8, pixel width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel offered
- in_ready  out  1  loader can accept a pixel (high only in FILL)
- in_pixel  in  IntSize  pixel value
- in_last  in  1  producer marks the final pixel of a frame
- frame_data  out  IntSize*196  packed frame; pixel (r,c) at bits [IntSize*(14r+c) +: IntSize]
- pool_state  out  21  pooling window index, 0..48, driven to the selector
- pool_en  out  1  pool_state is valid this cycle (SWEEP only)
- frame_done  out  1  sweep finished; frame held
- frame_ack  in  1  consumer releases the frame
- err_len  out  1  sticky framing error, cleared only by reset

## Operation
- States:
  - FILL (reset state), SWEEP, WAIT_ACK.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready, write in_pixel to slot wr_idx, then wr_idx++.
  - wr_idx is 8 bits, range 0..195.
- Frame completion:
  - Accepting slot 195 moves the block to SWEEP and resets wr_idx to 0.
  - If in_last=0 on slot 195, set err_len; the frame still completes.
- Early in_last:
  - in_last=1 on a slot below 195 sets err_len, writes the pixel, and resets wr_idx to 0.
  - The partial frame is discarded and the block stays in FILL.
- SWEEP:
  - pool_en=1; pool_state starts at 0 and increments each cycle.
  - After pool_state=48, move to WAIT_ACK and drive pool_state back to 0.
- WAIT_ACK:
  - frame_done=1.
  - frame_ack=1 returns the block to FILL; frame_ack in any other state is ignored.
- frame_data is stable from the end of FILL until the ack.
  - It is not cleared between frames; slots are overwritten as the new frame arrives.
- Sweep length is fixed at 49 regardless of downstream behaviour. The sweep has no back-pressure.

## Timing
- Reset values:
  - in_ready=1, frame_data=0, pool_state=0, pool_en=0, frame_done=0, err_len=0.
  - State=FILL, wr_idx=0.
- Write latency: a pixel accepted at edge t is visible on frame_data after edge t.
- Sweep timing (slot 195 accepted at edge t):
  - From t+1: in_ready=0, pool_en=1, pool_state=0.
  - From t+49: pool_state=48.
  - From t+50: frame_done=1, pool_en=0.
- Ack timing: frame_ack sampled high at edge a → from a+1, frame_done=0 and in_ready=1.
  - Minimum frame period: 196+49+1 = 246 cycles.
- All outputs are registered; there is no combinational path from input to output.
- Asserting rst_n low mid-frame or mid-sweep immediately clears all state to the reset values.

## Configuration
- FMAP_RELU_EN defined:
  - in_pixel is treated as signed two's complement.
  - Negative values are written as 0 (fused ReLU); non-negative values pass unchanged.
- FMAP_RELU_EN undefined: in_pixel is written verbatim.
- Handshake and timing are identical in both builds.

## Structure
- Package fmap_pkg holds:
  - IntSize default, FMAP_DIM=14, FMAP_PIXELS=196, POOL_OUTS=49, POOL_STATE_W=21.
  - The state enum {FILL, SWEEP, WAIT_ACK}.
- No sub-module. The parent instantiates the pooling selector beside this block and connects frame_data and pool_state.

## Test plan
- Frame and sweep: stream pixels 0..195 with in_last on the final pixel.
  - frame_data slot k must equal k; slot 14 is at bits [119:112].
  - pool_state must step 0..48 over 49 cycles, then frame_done=1.
  - err_len must stay 0.
- Back-pressure: toggle in_valid randomly.
  - Same packed result; in_ready=0 throughout SWEEP and WAIT_ACK.
- Early in_last: assert in_last on pixel 10.
  - err_len=1; wr_idx restarts.
  - A following correct 196-pixel frame completes normally.
- Held frame and ack:
  - frame_ack during SWEEP is ignored.
  - Hold WAIT_ACK for 20 cycles: frame_data unchanged.
  - Ack → in_ready=1 next cycle.
- Reset mid-sweep at pool_state=20: all outputs return to reset values immediately; frame_data=0.
- FMAP_RELU_EN build: pixel 8'hF0 is stored as 0 and 8'h7F is stored as 8'h7F; without the macro, 8'hF0 is stored as 8'hF0.

Source files
------------

// File: rtl/fmap_pkg.sv
// Shared constants and state encoding for the 14x14 feature-map loader.
package fmap_pkg;

    localparam int unsigned INT_SIZE     = 8;
    localparam int unsigned FMAP_DIM     = 14;
    localparam int unsigned FMAP_PIXELS  = FMAP_DIM * FMAP_DIM;
    localparam int unsigned POOL_OUTS    = 49;
    localparam int unsigned POOL_STATE_W = 21;
    localparam int unsigned WR_IDX_W     = 8;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SWEEP    = 2'd1,
        WAIT_ACK = 2'd2
    } fmap_state_e;

endpackage : fmap_pkg

// File: rtl/fmap_loader_14x14.sv
// fmap_loader_14x14
// Packs a row-major stream of conv output pixels into a flat 14x14 frame,
// then sweeps the pool window index 0..48 and holds the frame until acked.
//
// Build option: define FMAP_RELU_EN to treat in_pixel as signed and store
// negative values as 0 (fused ReLU). Undefined: pixels are stored verbatim.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     pixel offered
//   in_ready     loader accepts a pixel (FILL only)
//   in_pixel     pixel value
//   in_last      producer marks final pixel of a frame
//   frame_data   packed frame, pixel (r,c) at [IntSize*(14r+c) +: IntSize]
//   pool_state   pooling window index 0..48
//   pool_en      pool_state valid (SWEEP only)
//   frame_done   sweep finished, frame held
//   frame_ack    consumer releases the frame
//   err_len      sticky framing error
module fmap_loader_14x14
    import fmap_pkg::*;
#(
    parameter int unsigned IntSize = INT_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IntSize-1:0]            in_pixel,
    input  logic                          in_last,
    output logic [IntSize*FMAP_PIXELS-1:0] frame_data,
    output logic [POOL_STATE_W-1:0]       pool_state,
    output logic                          pool_en,
    output logic                          frame_done,
    input  logic                          frame_ack,
    output logic                          err_len
);

    localparam logic [WR_IDX_W-1:0]     LastSlot = WR_IDX_W'(FMAP_PIXELS - 1);
    localparam logic [POOL_STATE_W-1:0] LastPool = POOL_STATE_W'(POOL_OUTS - 1);

    fmap_state_e state, state_nx;

    logic [WR_IDX_W-1:0]                  wr_idx;
    logic [FMAP_PIXELS-1:0][IntSize-1:0]  pix_q;
    logic [IntSize-1:0]                   pix_w;
    logic                                 accept;
    logic                                 last_slot;
    logic                                 pool_last;

    logic                    in_ready_d;
    logic                    pool_en_d;
    logic                    frame_done_d;
    logic [POOL_STATE_W-1:0] pool_state_d;

    // in_ready is a register that mirrors state==FILL
    assign accept    = in_valid & in_ready;
    assign last_slot = (wr_idx == LastSlot);
    assign pool_last = (pool_state == LastPool);

    // Optional fused ReLU on the incoming pixel
`ifdef FMAP_RELU_EN
    assign pix_w = in_pixel[IntSize-1] ? '0 : in_pixel;
`else
    assign pix_w = in_pixel;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:     if (accept && last_slot) state_nx = SWEEP;
            SWEEP:    if (pool_last)           state_nx = WAIT_ACK;
            WAIT_ACK: if (frame_ack)           state_nx = FILL;
            default:                           state_nx = FILL;
        endcase
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        in_ready_d   = 1'b0;
        pool_en_d    = 1'b0;
        frame_done_d = 1'b0;
        pool_state_d = '0;
        unique case (state_nx)
            FILL:     in_ready_d   = 1'b1;
            SWEEP:    pool_en_d    = 1'b1;
            WAIT_ACK: frame_done_d = 1'b1;
            default:  in_ready_d   = 1'b1;
        endcase
        // Counter only advances while already sweeping; entry and exit see 0
        if (state == SWEEP && !pool_last) begin
            pool_state_d = pool_state + POOL_STATE_W'(1);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b1;
            pool_en    <= 1'b0;
            frame_done <= 1'b0;
            pool_state <= '0;
        end else begin
            in_ready   <= in_ready_d;
            pool_en    <= pool_en_d;
            frame_done <= frame_done_d;
            pool_state <= pool_state_d;
        end
    end

    // Write pointer, frame store and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            pix_q   <= '0;
            err_len <= 1'b0;
        end else if (accept) begin
            pix_q[wr_idx] <= pix_w;
            // in_last must coincide exactly with the final slot
            if (last_slot ^ in_last) begin
                err_len <= 1'b1;
            end
            // Early in_last discards the partial frame and restarts at slot 0
            if (last_slot || in_last) begin
                wr_idx <= '0;
            end else begin
                wr_idx <= wr_idx + WR_IDX_W'(1);
            end
        end
    end

    assign frame_data = pix_q;

endmodule : fmap_loader_14x14

// File: tb/tb_fmap_loader_14x14.sv
// Directed bench for fmap_loader_14x14: frame packing, sweep timing,
// back-pressure, framing errors, held frame/ack and mid-sweep reset.
module tb_fmap_loader_14x14;

    localparam int unsigned FW = 8 * 196;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          in_last;
    logic [FW-1:0] frame_data;
    logic [20:0]   pool_state;
    logic          pool_en;
    logic          frame_done;
    logic          frame_ack;
    logic          err_len;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_pix [196];

    fmap_loader_14x14 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_last    (in_last),
        .frame_data (frame_data),
        .pool_state (pool_state),
        .pool_en    (pool_en),
        .frame_done (frame_done),
        .frame_ack  (frame_ack),
        .err_len    (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] p);
`ifdef FMAP_RELU_EN
        return p[7] ? 8'h00 : p;
`else
        return p;
`endif
    endfunction

    function automatic logic [FW-1:0] exp_frame();
        logic [FW-1:0] v;
        v = '0;
        for (int k = 0; k < 196; k++) v[8*k +: 8] = exp_pix[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel after `gaps` idle cycles; returns #1 after the accepting edge
    task automatic push(input logic [7:0] p, input logic last, input int gaps);
        int   n;
        logic rdy;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_last  = last;
        n = 0;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("push_timeout", FW'(0), FW'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Full 49-cycle sweep starting at t+1; optional frame_ack pulse mid-sweep
    task automatic run_sweep(input string tag, input logic ack_mid);
        for (int i = 0; i < 49; i++) begin
            check({tag, "_pool_state"}, FW'(pool_state), FW'(i));
            check({tag, "_pool_en"}, FW'(pool_en), FW'(1));
            check({tag, "_in_ready_sweep"}, FW'(in_ready), FW'(0));
            check({tag, "_done_sweep"}, FW'(frame_done), FW'(0));
            if (ack_mid) frame_ack = (i >= 5 && i < 10);
            tick();
        end
        frame_ack = 1'b0;
        check({tag, "_done"}, FW'(frame_done), FW'(1));
        check({tag, "_pool_en_off"}, FW'(pool_en), FW'(0));
        check({tag, "_pool_state_zero"}, FW'(pool_state), FW'(0));
    endtask

    // Hold WAIT_ACK with garbage offered, then ack
    task automatic hold_and_ack(input string tag);
        in_valid = 1'b1;
        in_pixel = 8'hAA;
        in_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check({tag, "_held"}, frame_data, exp_frame());
            check({tag, "_in_ready_wait"}, FW'(in_ready), FW'(0));
            check({tag, "_done_wait"}, FW'(frame_done), FW'(1));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check({tag, "_ack_done"}, FW'(frame_done), FW'(0));
        check({tag, "_ack_ready"}, FW'(in_ready), FW'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, FW'(in_ready), FW'(1));
        check({tag, "_frame_data"}, frame_data, FW'(0));
        check({tag, "_pool_state"}, FW'(pool_state), FW'(0));
        check({tag, "_pool_en"}, FW'(pool_en), FW'(0));
        check({tag, "_frame_done"}, FW'(frame_done), FW'(0));
        check({tag, "_err_len"}, FW'(err_len), FW'(0));
    endtask

    initial begin
        logic [7:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        for (int k = 0; k < 196; k++) exp_pix[k] = 8'h00;

        tick();
        tick();
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_vals("post_rst");

        // Frame A: pixels 0..195, no gaps
        for (int k = 0; k < 196; k++) begin
            v = 8'(k);
            exp_pix[k] = stored(v);
            push(v, k == 195, 0);
            if (k < 195) check("a_ready_fill", FW'(in_ready), FW'(1));
        end
        check("a_frame", frame_data, exp_frame());
        check("a_slot14", FW'(frame_data[119:112]), FW'(8'd14));
        check("a_slot195", FW'(frame_data[1567:1560]), FW'(8'd195));
        check("a_in_ready_off", FW'(in_ready), FW'(0));
        run_sweep("a", 1'b0);
        check("a_err", FW'(err_len), FW'(0));
        hold_and_ack("a");

        // Frame B: random gaps, ack pulsed during sweep (ignored)
        for (int k = 0; k < 196; k++) begin
            v = 8'((k * 3 + 7) & 8'h7F);
            exp_pix[k] = stored(v);
            push(v, k == 195, int'($urandom_range(0, 2)));
        end
        check("b_frame", frame_data, exp_frame());
        run_sweep("b", 1'b1);
        check("b_err", FW'(err_len), FW'(0));
        hold_and_ack("b");

        // Early in_last on pixel 10
        for (int k = 0; k <= 10; k++) begin
            v = 8'(8'h40 + k);
            exp_pix[k] = stored(v);
            push(v, k == 10, 0);
        end
        check("early_err", FW'(err_len), FW'(1));
        check("early_ready", FW'(in_ready), FW'(1));
        check("early_pool_en", FW'(pool_en), FW'(0));
        check("early_frame", frame_data, exp_frame());

        // Frame C after early last: must restart at slot 0
        for (int k = 0; k < 196; k++) begin
            v = 8'(8'h7F - (k & 8'h3F));
            exp_pix[k] = stored(v);
            push(v, k == 195, 0);
        end
        check("c_frame", frame_data, exp_frame());
        check("c_slot0", FW'(frame_data[7:0]), FW'(8'h7F));
        run_sweep("c", 1'b0);
        check("c_err_sticky", FW'(err_len), FW'(1));
        hold_and_ack("c");

        // Frame D: ReLU boundary values, reset at pool_state=20
        for (int k = 0; k < 196; k++) begin
            v = (k == 0) ? 8'hF0 : (k == 1) ? 8'h7F : 8'(k & 8'h3F);
            exp_pix[k] = stored(v);
            push(v, k == 195, 0);
        end
`ifdef FMAP_RELU_EN
        check("d_relu_f0", FW'(frame_data[7:0]), FW'(8'h00));
`else
        check("d_raw_f0", FW'(frame_data[7:0]), FW'(8'hF0));
`endif
        check("d_7f", FW'(frame_data[15:8]), FW'(8'h7F));
        check("d_frame", frame_data, exp_frame());
        for (int i = 0; i < 20; i++) tick();
        check("d_pool_20", FW'(pool_state), FW'(20));
        rst_n = 1'b0;
        #1;
        check_reset_vals("midsweep_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 196; k++) exp_pix[k] = 8'h00;
        check_reset_vals("after_midsweep_rst");

        // Frame E: missing in_last on slot 195, frame still completes
        for (int k = 0; k < 196; k++) begin
            v = 8'(k ^ 8'h15);
            exp_pix[k] = stored(v);
            push(v, 1'b0, 0);
        end
        check("e_err", FW'(err_len), FW'(1));
        check("e_frame", frame_data, exp_frame());
        run_sweep("e", 1'b0);
        hold_and_ack("e");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fmap_loader_14x14
